// File: rtl/branch_sched_pkg.sv
// Shared types for the branch scheduler: branch kinds, queued entry, FSM states.
// Also holds the sequential-PC helper used for the not-taken redirect.
package branch_sched_pkg;

   localparam int BS_TAG_W = 4;

   typedef enum logic [1:0] {
      BR_EQ  = 2'd0,
      BR_LT  = 2'd1,
      BR_LTU = 2'd2,
      BR_RSV = 2'd3
   } branch_type_t;

   typedef struct packed {
      branch_type_t          btype;
      logic                  gate_sel;
      logic [31:0]           reg_a;
      logic [31:0]           reg_b;
      logic [31:0]           pc;
      logic [31:0]           imm;
      logic                  pred_taken;
      logic [BS_TAG_W-1:0]   tag;
   } branch_entry_t;

   typedef logic [1:0] bsched_state_t;

   localparam bsched_state_t S_IDLE    = 2'd0;
   localparam bsched_state_t S_BUSY    = 2'd1;
   localparam bsched_state_t S_RESOLVE = 2'd2;
   localparam bsched_state_t S_FLUSH   = 2'd3;

   // Wraps modulo 2^32 (0xFFFFFFFC -> 0x0).
   function automatic logic [31:0] seq_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/branch_sched_if.sv
// Issue / FU / resolution bundle of the branch scheduler.
// slave = scheduler side, master = issue stage + FU + ROB side.
interface branch_sched_if
   import branch_sched_pkg::*;
#(
   parameter int TAG_W = BS_TAG_W
) ();

   logic             iss_valid;
   logic             iss_ready;
   logic [1:0]       iss_branch_type;
   logic             iss_gate_sel;
   logic [31:0]      iss_reg_a;
   logic [31:0]      iss_reg_b;
   logic [31:0]      iss_pc;
   logic [31:0]      iss_imm;
   logic             iss_pred_taken;
   logic [TAG_W-1:0] iss_tag;

   logic             fu_branch;
   logic [1:0]       fu_branch_type;
   logic             fu_gate_sel;
   logic [31:0]      fu_reg_a;
   logic [31:0]      fu_reg_b;
   logic [31:0]      fu_current_pc;
   logic [31:0]      fu_imm;
   logic             fu_done;
   logic             fu_taken;
   logic [31:0]      fu_target;

   logic             res_valid;
   logic [TAG_W-1:0] res_tag;
   logic             res_mispredict;
   logic             flush;
   logic [31:0]      redirect_pc;

   modport slave (
      input  iss_valid, iss_branch_type, iss_gate_sel,
      input  iss_reg_a, iss_reg_b, iss_pc, iss_imm,
      input  iss_pred_taken, iss_tag,
      output iss_ready,
      output fu_branch, fu_branch_type, fu_gate_sel,
      output fu_reg_a, fu_reg_b, fu_current_pc, fu_imm,
      input  fu_done, fu_taken, fu_target,
      output res_valid, res_tag, res_mispredict,
      output flush, redirect_pc
   );

   modport master (
      output iss_valid, iss_branch_type, iss_gate_sel,
      output iss_reg_a, iss_reg_b, iss_pc, iss_imm,
      output iss_pred_taken, iss_tag,
      input  iss_ready,
      input  fu_branch, fu_branch_type, fu_gate_sel,
      input  fu_reg_a, fu_reg_b, fu_current_pc, fu_imm,
      output fu_done, fu_taken, fu_target,
      input  res_valid, res_tag, res_mispredict,
      input  flush, redirect_pc
   );

endinterface

// File: rtl/branch_sched_fifo.sv
// In-order pending-branch queue: DEPTH entries, push/pop/clear, full/empty.
// Ports: clk, rst (sync, high), push/wdata, pop/rdata (head), clear, full, empty.
module branch_sched_fifo
   import branch_sched_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  branch_entry_t wdata,
   input  logic          pop,
   input  logic          clear,
   output branch_entry_t rdata,
   output logic          full,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);

   branch_entry_t mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full && !clear;
   assign do_pop  = pop && !empty && !clear;
   assign rdata   = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + (AW+1)'(do_push)
                           - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: only entries below count are ever read out.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/branch_sched.sv
// Schedules queued branches onto the single branch FU, one at a time, and
// reports resolution; on mispredict flushes/redirects and drops the queue.
// Ports: CLK, nRST (sync, active-high), bus (branch_sched_if.slave).
module branch_sched
   import branch_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = BS_TAG_W
) (
   input  logic           CLK,
   input  logic           nRST,
   branch_sched_if.slave  bus
);

   bsched_state_t state_q, state_d;
   branch_entry_t cur_q, cur_d;
   logic          mis_q, mis_d;
   logic [31:0]   redir_q, redir_d;

   branch_entry_t in_entry;
   branch_entry_t head;
   branch_entry_t fu_op;
   logic [TAG_W-1:0] iss_tag_w;
   logic          full;
   logic          empty;
   logic          push;
   logic          launch;
   logic          q_clear;

   assign iss_tag_w     = bus.iss_tag;
   assign launch        = (state_q == S_IDLE) && !empty;
   assign q_clear       = (state_q == S_FLUSH);
   assign bus.iss_ready = !full && (state_q != S_FLUSH);
   assign push          = bus.iss_valid && bus.iss_ready;

   always_comb begin
      in_entry            = '0;
      in_entry.btype      = branch_type_t'(bus.iss_branch_type);
      in_entry.gate_sel   = bus.iss_gate_sel;
      in_entry.reg_a      = bus.iss_reg_a;
      in_entry.reg_b      = bus.iss_reg_b;
      in_entry.pc         = bus.iss_pc;
      in_entry.imm        = bus.iss_imm;
      in_entry.pred_taken = bus.iss_pred_taken;
      in_entry.tag        = iss_tag_w;
   end

   branch_sched_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst   (nRST),
      .push  (push),
      .wdata (in_entry),
      .pop   (launch),
      .clear (q_clear),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      mis_d   = mis_q;
      redir_d = redir_q;
      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               state_d = S_BUSY;
               cur_d   = head;
            end
         end
         S_BUSY: begin
            if (bus.fu_done) begin
               state_d = S_RESOLVE;
               mis_d   = bus.fu_taken != cur_q.pred_taken;
               redir_d = bus.fu_taken ? bus.fu_target
                                      : seq_pc(cur_q.pc);
            end
         end
         S_RESOLVE: state_d = mis_q ? S_FLUSH : S_IDLE;
         S_FLUSH:   state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (nRST) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
         mis_q   <= 1'b0;
         redir_q <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         mis_q   <= mis_d;
         redir_q <= redir_d;
      end
   end

   // In the launch cycle the head is shown directly so the FU sees the
   // operands alongside the pulse; afterwards the latched copy holds them.
   assign fu_op              = launch ? head : cur_q;
   assign bus.fu_branch      = launch;
   assign bus.fu_branch_type = fu_op.btype;
   assign bus.fu_gate_sel    = fu_op.gate_sel;
   assign bus.fu_reg_a       = fu_op.reg_a;
   assign bus.fu_reg_b       = fu_op.reg_b;
   assign bus.fu_current_pc  = fu_op.pc;
   assign bus.fu_imm         = fu_op.imm;

   assign bus.res_valid      = (state_q == S_RESOLVE);
   assign bus.res_tag        = bus.res_valid ? cur_q.tag : '0;
   assign bus.res_mispredict = bus.res_valid && mis_q;
   assign bus.flush          = (state_q == S_FLUSH);
   assign bus.redirect_pc    = bus.flush ? redir_q : '0;

endmodule
